// File: rtl/rot_pkg.sv
// Shared types and helpers for the rotary-encoder controller.
//   step_sel_t  : step-size selector advanced by the push-button
//   dec_state_t : quadrature decoder state
//   step_of()   : maps a selector to one of the three configured step sizes
package rot_pkg;

  typedef enum logic [1:0] {
    STEP_1   = 2'd0,
    STEP_10  = 2'd1,
    STEP_100 = 2'd2
  } step_sel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UP_WAIT = 2'd1,
    DN_WAIT = 2'd2
  } dec_state_t;

  // Step sizes are module parameters, so the caller passes them in.
  function automatic int unsigned step_of(input step_sel_t sel, input int unsigned s0,
                                          input int unsigned s1, input int unsigned s2);
    case (sel)
      STEP_10:  return s1;
      STEP_100: return s2;
      default:  return s0;
    endcase
  endfunction

endpackage

// File: rtl/rot_debounce.sv
// Two-flop synchroniser followed by a stability counter for one encoder contact.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   rst_val_i : value held by the synchroniser and debounced output during reset
//   async_i   : raw asynchronous contact input
//   deb_o     : debounced level; follows the synchronised input after DEB_LEN
//               consecutive cycles of disagreement
module rot_debounce #(
  parameter int unsigned DEB_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rst_val_i,
  input  logic async_i,
  output logic deb_o
);

  localparam int unsigned CntW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DEB_LEN - 1);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    // Any cycle of agreement clears the run; the DEB_LEN-th differing cycle commits.
    if (sync2_q != deb_q) begin
      if (cnt_q == LastCnt) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= rst_val_i;
      sync2_q <= rst_val_i;
      deb_q   <= rst_val_i;
      cnt_q   <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/rotary_encoder_ctrl.sv
// Front-panel rotary-encoder controller: debounces A/B/C, decodes quadrature
// detents into step requests, keeps a bounded accumulator and publishes it at a
// fixed rate.
//   Fg_clk   : clock            Reset    : async active-high reset
//   Rot_A/B  : encoder channels Rot_C    : push-button (cycles step size)
//   Floor    : dynamic lower clamp
//   Load     : preset strobe    Load_val : preset value
//   address  : published value  FreqChng : pulse when published value changed
//   Step_sel : step index       Dir      : direction of last detent (1 = up)
module rotary_encoder_ctrl
  import rot_pkg::*;
#(
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned CNT_MIN    = 0,
  parameter int unsigned CNT_MAX    = 1800,
  parameter int unsigned STEP0      = 1,
  parameter int unsigned STEP1      = 10,
  parameter int unsigned STEP2      = 100,
  parameter int unsigned DEB_LEN    = 4,
  parameter int unsigned UPD_PERIOD = 2400000,
  parameter int unsigned WRAP       = 0
) (
  input  logic             Fg_clk,
  input  logic             Reset,
  input  logic             Rot_A,
  input  logic             Rot_B,
  input  logic             Rot_C,
  input  logic [CNT_W-1:0] Floor,
  input  logic             Load,
  input  logic [CNT_W-1:0] Load_val,
  output logic [CNT_W-1:0] address,
  output logic             FreqChng,
  output logic [1:0]       Step_sel,
  output logic             Dir
);

  localparam int unsigned W1    = CNT_W + 1;
  localparam int unsigned TickW = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(UPD_PERIOD - 1);
  localparam logic [W1-1:0]    MinExt   = W1'(CNT_MIN);
  localparam logic [W1-1:0]    MaxExt   = W1'(CNT_MAX);

  logic a_deb, b_deb, c_deb;
  logic a_dly_q, b_dly_q, c_dly_q;
  logic a_fall_q, a_fall_d, b_fall_q, b_fall_d, c_rise_q, c_rise_d;

  dec_state_t       state_q, state_d;
  step_sel_t        sel_q, sel_d;
  logic             dir_q, dir_d;
  logic             step_up, step_dn;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic             tick;
  logic [CNT_W-1:0] addr_q, addr_d;
  logic             chng_q, chng_d;

  logic [W1-1:0] lo, cnt_ext, step_ext, sum, lo_step, floor_ext, load_ext;

  rot_debounce #(.DEB_LEN(DEB_LEN)) u_deb_a (
    .clk_i(Fg_clk), .rst_i(Reset), .rst_val_i(1'b1), .async_i(Rot_A), .deb_o(a_deb)
  );
  rot_debounce #(.DEB_LEN(DEB_LEN)) u_deb_b (
    .clk_i(Fg_clk), .rst_i(Reset), .rst_val_i(1'b1), .async_i(Rot_B), .deb_o(b_deb)
  );
  rot_debounce #(.DEB_LEN(DEB_LEN)) u_deb_c (
    .clk_i(Fg_clk), .rst_i(Reset), .rst_val_i(1'b0), .async_i(Rot_C), .deb_o(c_deb)
  );

  // Edge pulses are registered so the decoder sees clean one-cycle events.
  always_comb begin
    a_fall_d = a_dly_q & ~a_deb;
    b_fall_d = b_dly_q & ~b_deb;
    c_rise_d = ~c_dly_q & c_deb;
  end

  // Quadrature decoder: the first falling channel decides direction, the other
  // channel's fall closes the detent.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    case (state_q)
      IDLE: begin
        if (b_fall_q && !a_fall_q) begin
          state_d = UP_WAIT;
          step_up = 1'b1;
          dir_d   = 1'b1;
        end else if (a_fall_q && !b_fall_q) begin
          state_d = DN_WAIT;
          step_dn = 1'b1;
          dir_d   = 1'b0;
        end
      end
      UP_WAIT: if (a_fall_q) state_d = IDLE;
      DN_WAIT: if (b_fall_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    if (c_rise_q) begin
      case (sel_q)
        STEP_1:  sel_d = STEP_10;
        STEP_10: sel_d = STEP_100;
        default: sel_d = STEP_1;
      endcase
    end
  end

  // Accumulator; one extra bit keeps sums and lo+step free of overflow.
  always_comb begin
    floor_ext = {1'b0, Floor};
    load_ext  = {1'b0, Load_val};
    cnt_ext   = {1'b0, cnt_q};
    lo        = (floor_ext > MinExt) ? floor_ext : MinExt;
    step_ext  = W1'(step_of(sel_q, STEP0, STEP1, STEP2));
    sum       = cnt_ext + step_ext;
    lo_step   = lo + step_ext;
    cnt_d     = cnt_q;
    if (cnt_ext < lo) begin
      cnt_d = CNT_W'(lo);
    end else if (Load) begin
      if (load_ext < lo)          cnt_d = CNT_W'(lo);
      else if (load_ext > MaxExt) cnt_d = CNT_W'(MaxExt);
      else                        cnt_d = Load_val;
    end else if (step_up) begin
      // Wrap only from the bound itself; otherwise land on the bound first.
      if (sum > MaxExt) cnt_d = (WRAP != 0 && cnt_ext == MaxExt) ? CNT_W'(lo) : CNT_W'(MaxExt);
      else              cnt_d = CNT_W'(sum);
    end else if (step_dn) begin
      if (cnt_ext < lo_step) cnt_d = (WRAP != 0 && cnt_ext == lo) ? CNT_W'(MaxExt) : CNT_W'(lo);
      else                   cnt_d = CNT_W'(cnt_ext - step_ext);
    end
  end

  always_comb begin
    tick   = (tick_q == TickLast);
    tick_d = tick ? '0 : tick_q + 1'b1;
    addr_d = tick ? cnt_q : addr_q;
    chng_d = tick && (addr_q != cnt_q);
  end

  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      a_dly_q  <= 1'b1;
      b_dly_q  <= 1'b1;
      c_dly_q  <= 1'b0;
      a_fall_q <= 1'b0;
      b_fall_q <= 1'b0;
      c_rise_q <= 1'b0;
      state_q  <= IDLE;
      sel_q    <= STEP_1;
      dir_q    <= 1'b0;
      cnt_q    <= CNT_W'(CNT_MIN);
      tick_q   <= '0;
      addr_q   <= CNT_W'(CNT_MIN);
      chng_q   <= 1'b0;
    end else begin
      a_dly_q  <= a_deb;
      b_dly_q  <= b_deb;
      c_dly_q  <= c_deb;
      a_fall_q <= a_fall_d;
      b_fall_q <= b_fall_d;
      c_rise_q <= c_rise_d;
      state_q  <= state_d;
      sel_q    <= sel_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      addr_q   <= addr_d;
      chng_q   <= chng_d;
    end
  end

  assign address  = addr_q;
  assign FreqChng = chng_q;
  assign Step_sel = sel_q;
  assign Dir      = dir_q;

endmodule

// File: tb/tb_rotary_encoder_ctrl.sv
// Directed bench for rotary_encoder_ctrl. Two instances share all inputs: one
// saturating (WRAP=0) and one wrapping (WRAP=1); UPD_PERIOD=16, DEB_LEN=4.
module tb_rotary_encoder_ctrl;

  localparam int unsigned CntW = 11;
  localparam int unsigned Upd  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            rot_a, rot_b, rot_c, load;
  logic [CntW-1:0] floor_v, load_val;
  logic [CntW-1:0] addr0, addr1;
  logic            chng0, chng1, dir0, dir1;
  logic [1:0]      sel0, sel1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  // Cycles since reset release; publishes land on edges where cyc % 16 == 0.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  rotary_encoder_ctrl #(.UPD_PERIOD(Upd), .DEB_LEN(4), .WRAP(0)) dut (
    .Fg_clk(clk), .Reset(rst), .Rot_A(rot_a), .Rot_B(rot_b), .Rot_C(rot_c),
    .Floor(floor_v), .Load(load), .Load_val(load_val),
    .address(addr0), .FreqChng(chng0), .Step_sel(sel0), .Dir(dir0)
  );

  rotary_encoder_ctrl #(.UPD_PERIOD(Upd), .DEB_LEN(4), .WRAP(1)) dut_w (
    .Fg_clk(clk), .Reset(rst), .Rot_A(rot_a), .Rot_B(rot_b), .Rot_C(rot_c),
    .Floor(floor_v), .Load(load), .Load_val(load_val),
    .address(addr1), .FreqChng(chng1), .Step_sel(sel1), .Dir(dir1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance to just after the next publish edge (at most Upd cycles).
  task automatic next_pub();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % Upd != 0);
  endtask

  task automatic cw();
    rot_b = 1'b0; wait_cyc(12);
    rot_a = 1'b0; wait_cyc(12);
    rot_b = 1'b1; wait_cyc(12);
    rot_a = 1'b1; wait_cyc(12);
  endtask

  task automatic ccw();
    rot_a = 1'b0; wait_cyc(12);
    rot_b = 1'b0; wait_cyc(12);
    rot_a = 1'b1; wait_cyc(12);
    rot_b = 1'b1; wait_cyc(12);
  endtask

  task automatic press_c(input int hold);
    rot_c = 1'b1; wait_cyc(hold);
    rot_c = 1'b0; wait_cyc(12);
  endtask

  task automatic do_load(input logic [CntW-1:0] val);
    load_val = val;
    load     = 1'b1;
    wait_cyc(1);
    load     = 1'b0;
  endtask

  // CW detent with Load pulsed in the exact cycle the step request is raised
  // (7 edges after B is driven: 2 sync + 4 debounce + 1 edge register).
  task automatic cw_with_load(input logic [CntW-1:0] val);
    rot_b = 1'b0; wait_cyc(7);
    do_load(val);
    wait_cyc(4);
    rot_a = 1'b0; wait_cyc(12);
    rot_b = 1'b1; wait_cyc(12);
    rot_a = 1'b1; wait_cyc(12);
  endtask

  initial begin
    rst = 1'b1; rot_a = 1'b1; rot_b = 1'b1; rot_c = 1'b0;
    load = 1'b0; load_val = '0; floor_v = '0;
    wait_cyc(3);
    check("rst_address", 32'(addr0), 0);
    check("rst_freqchng", 32'(chng0), 0);
    check("rst_step_sel", 32'(sel0), 0);
    check("rst_dir", 32'(dir0), 0);
    rst = 1'b0;

    // First CW detent: count 0 -> 1, published at cyc 16 with a change pulse.
    rot_b = 1'b0;
    wait_cyc(10);
    next_pub();
    check("cw1_address", 32'(addr0), 1);
    check("cw1_freqchng_hi", 32'(chng0), 1);
    wait_cyc(1);
    check("cw1_freqchng_lo", 32'(chng0), 0);
    rot_a = 1'b0; wait_cyc(12);
    rot_b = 1'b1; wait_cyc(12);
    rot_a = 1'b1; wait_cyc(12);
    next_pub();
    check("cw1_addr_hold", 32'(addr0), 1);
    check("cw1_no_rechng", 32'(chng0), 0);
    check("cw1_dir", 32'(dir0), 1);

    // Long press advances Step_sel only once; three detents of 10.
    press_c(50);
    check("press1_sel", 32'(sel0), 1);
    cw(); cw(); cw();
    next_pub();
    check("step10_address", 32'(addr0), 31);
    press_c(20);
    check("press2_sel", 32'(sel0), 2);
    press_c(20);
    check("press3_sel", 32'(sel0), 0);
    press_c(20);
    press_c(20);
    check("press5_sel", 32'(sel0), 2);

    // Upper bound: saturate vs wrap.
    do_load(11'd1750);
    cw();
    next_pub();
    check("sat_1800", 32'(addr0), 1800);
    check("wrapinst_sat_1800", 32'(addr1), 1800);
    cw();
    next_pub();
    check("sat_hold_1800", 32'(addr0), 1800);
    check("wrap_up_to_0", 32'(addr1), 0);
    ccw();
    next_pub();
    check("sat_down_1700", 32'(addr0), 1700);
    check("wrap_down_to_1800", 32'(addr1), 1800);
    check("ccw_dir", 32'(dir0), 0);

    // Dynamic floor.
    do_load(11'd30);
    floor_v = 11'd800;
    next_pub();
    check("floor_address", 32'(addr0), 800);
    check("floor_freqchng", 32'(chng0), 1);
    do_load(11'd850);
    ccw();
    next_pub();
    check("floor_ccw_sat", 32'(addr0), 800);
    check("wrapinst_floor_ccw", 32'(addr1), 800);

    // Glitch and simultaneous falls must not move the count or Dir.
    cw();
    next_pub();
    check("pre_glitch_addr", 32'(addr0), 900);
    rot_a = 1'b0; wait_cyc(3);
    rot_a = 1'b1; wait_cyc(20);
    rot_a = 1'b0; rot_b = 1'b0; wait_cyc(12);
    rot_a = 1'b1; rot_b = 1'b1; wait_cyc(12);
    next_pub();
    check("glitch_addr", 32'(addr0), 900);
    check("glitch_dir", 32'(dir0), 1);

    // Load beats a simultaneous step request.
    floor_v = '0;
    cw_with_load(11'd2000);
    next_pub();
    check("load_clamp_max", 32'(addr0), 1800);
    check("wrapinst_load_clamp", 32'(addr1), 1800);
    cw_with_load(11'd500);
    next_pub();
    check("load_drops_step", 32'(addr0), 500);

    // Reset in the middle of a CW detent (decoder in UP_WAIT).
    rot_b = 1'b0;
    wait_cyc(12);
    rst = 1'b1;
    #2;
    check("midrst_address", 32'(addr0), 0);
    check("midrst_step_sel", 32'(sel0), 0);
    check("midrst_dir", 32'(dir0), 0);
    check("midrst_freqchng", 32'(chng0), 0);
    wait_cyc(3);
    rst = 1'b0;
    // B is still low, so after release it reads as a fresh fall from IDLE.
    wait_cyc(12);
    rot_a = 1'b0; wait_cyc(12);
    rot_b = 1'b1; wait_cyc(12);
    rot_a = 1'b1; wait_cyc(12);
    next_pub();
    check("postrst_address", 32'(addr0), 1);
    check("postrst_dir", 32'(dir0), 1);
    check("wrapinst_postrst", 32'(addr1), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
